microcode_sequencer: RTL and testbench

Generates the 9-bit microprogram counter that addresses the on-chip microcode ROM. It consumes the decoded sequencing fields of the current microinstruction, the condition flags and the instruction-decoder dispatch address. The ROM has one cycle of registered read latency, so the sequencer alternates FETCH and EXEC cycles and tells the datapath when `micro_data` is current. It also owns a small microcode call/return stack and the interrupt entry point at instruction dispatch.

---
 rtl/microcode_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_microcode_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/microcode_sequencer.sv
// Microprogram sequencer: produces the registered 9-bit microcode ROM address,
// alternating FETCH/EXEC cycles to cover the ROM's one-cycle read latency.
// Owns the microcode call/return stack, interrupt entry at dispatch and the
// sticky stack-fault reporting.
module microcode_sequencer #(
    parameter logic [8:0] RESET_PC    = 9'd0,
    parameter logic [8:0] IRQ_PC      = 9'd480,
    parameter logic [8:0] FAULT_PC    = 9'd490,
    parameter int         STACK_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  mc_next_op,
    input  logic [8:0]  mc_target,
    input  logic [3:0]  mc_cond_sel,
    input  logic [15:0] cond_flags,
    input  logic [8:0]  decoder_pc,
    input  logic        decoder_valid,
    input  logic        irq_pending,
    input  logic        stall,
    output logic [8:0]  micro_pc,
    output logic        micro_valid,
    output logic        irq_ack,
    output logic        halted,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [2:0]  stack_level
);

    localparam int         AW      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [2:0] DEPTH_L = 3'(STACK_DEPTH);

    localparam logic [2:0] OP_INC      = 3'b000;
    localparam logic [2:0] OP_JUMP     = 3'b001;
    localparam logic [2:0] OP_BR_T     = 3'b010;
    localparam logic [2:0] OP_BR_F     = 3'b011;
    localparam logic [2:0] OP_CALL     = 3'b100;
    localparam logic [2:0] OP_RET      = 3'b101;
    localparam logic [2:0] OP_DISPATCH = 3'b110;
    localparam logic [2:0] OP_HALT     = 3'b111;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [8:0]  micro_pc_q, micro_pc_d;
    logic        micro_valid_q, micro_valid_d;
    logic        irq_ack_q, irq_ack_d;
    logic        halted_q, halted_d;
    logic        fault_q, fault_d;
    logic [1:0]  fault_code_q, fault_code_d;
    logic [2:0]  stack_level_q, stack_level_d;

    logic [8:0]  stack_mem_q [0:STACK_DEPTH-1];
    logic        push_en;
    logic [8:0]  pc_inc;
    logic        cond_bit;
    logic [AW-1:0] push_idx;
    logic [AW-1:0] pop_idx;

    assign pc_inc   = micro_pc_q + 9'd1;
    assign cond_bit = cond_flags[mc_cond_sel];
    assign push_idx = AW'(stack_level_q);
    assign pop_idx  = AW'(stack_level_q - 3'd1);

    // Next-state, next-PC, stack and fault decisions; only EXEC without stall acts.
    always_comb begin
        state_d       = state_q;
        micro_pc_d    = micro_pc_q;
        fault_d       = fault_q;
        fault_code_d  = fault_code_q;
        stack_level_d = stack_level_q;
        irq_ack_d     = 1'b0;
        push_en       = 1'b0;

        case (state_q)
            ST_FETCH: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (!stall) begin
                    state_d = ST_FETCH;
                    case (mc_next_op)
                        OP_INC:  micro_pc_d = pc_inc;
                        OP_JUMP: micro_pc_d = mc_target;
                        OP_BR_T: micro_pc_d = cond_bit ? mc_target : pc_inc;
                        OP_BR_F: micro_pc_d = cond_bit ? pc_inc : mc_target;
                        OP_CALL: begin
                            if (stack_level_q >= DEPTH_L) begin
                                // Overflow: drop the whole stack and enter the fault handler.
                                micro_pc_d    = FAULT_PC;
                                stack_level_d = 3'd0;
                                fault_d       = 1'b1;
                                if (fault_code_q == 2'b00) begin
                                    fault_code_d = 2'b01;
                                end
                            end else begin
                                push_en       = 1'b1;
                                stack_level_d = stack_level_q + 3'd1;
                                micro_pc_d    = mc_target;
                            end
                        end
                        OP_RET: begin
                            if (stack_level_q == 3'd0) begin
                                micro_pc_d = FAULT_PC;
                                fault_d    = 1'b1;
                                if (fault_code_q == 2'b00) begin
                                    fault_code_d = 2'b10;
                                end
                            end else begin
                                stack_level_d = stack_level_q - 3'd1;
                                micro_pc_d    = stack_mem_q[pop_idx];
                            end
                        end
                        OP_DISPATCH: begin
                            if (irq_pending) begin
                                micro_pc_d = IRQ_PC;
                                irq_ack_d  = 1'b1;
                            end else if (decoder_valid) begin
                                micro_pc_d = decoder_pc;
                            end else begin
                                // Nothing to dispatch yet: behave like a stall.
                                state_d = ST_EXEC;
                            end
                        end
                        OP_HALT: state_d = ST_HALT;
                    endcase
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        micro_valid_d = (state_d == ST_EXEC);
        halted_d      = (state_d == ST_HALT);
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_FETCH;
            micro_pc_q    <= RESET_PC;
            micro_valid_q <= 1'b0;
            irq_ack_q     <= 1'b0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
            fault_code_q  <= 2'b00;
            stack_level_q <= 3'd0;
        end else begin
            state_q       <= state_d;
            micro_pc_q    <= micro_pc_d;
            micro_valid_q <= micro_valid_d;
            irq_ack_q     <= irq_ack_d;
            halted_q      <= halted_d;
            fault_q       <= fault_d;
            fault_code_q  <= fault_code_d;
            stack_level_q <= stack_level_d;
        end
    end

    // Return-address storage; entries are left in place on pop and on reset.
    always_ff @(posedge clock) begin
        if (!reset && push_en) begin
            stack_mem_q[push_idx] <= pc_inc;
        end
    end

    assign micro_pc    = micro_pc_q;
    assign micro_valid = micro_valid_q;
    assign irq_ack     = irq_ack_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign fault_code  = fault_code_q;
    assign stack_level = stack_level_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench for microcode_sequencer: directed scenarios plus random
// microinstruction streams checked against a transaction-level model (PC value,
// return stack as a queue, sticky fault) and the FETCH/EXEC cycle timing.
module tb_microcode_sequencer;

    localparam logic [8:0] RST_PC = 9'd0;
    localparam logic [8:0] IRQ_PC = 9'd480;
    localparam logic [8:0] FLT_PC = 9'd490;
    localparam int         DEPTH  = 4;

    localparam logic [2:0] INC = 3'd0, JUMP = 3'd1, BR_T = 3'd2, BR_F = 3'd3;
    localparam logic [2:0] CALL = 3'd4, RET = 3'd5, DISP = 3'd6, HALT = 3'd7;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  mc_next_op = 3'd0;
    logic [8:0]  mc_target = 9'd0;
    logic [3:0]  mc_cond_sel = 4'd0;
    logic [15:0] cond_flags = 16'd0;
    logic [8:0]  decoder_pc = 9'd0;
    logic        decoder_valid = 1'b0;
    logic        irq_pending = 1'b0;
    logic        stall = 1'b0;
    logic [8:0]  micro_pc;
    logic        micro_valid;
    logic        irq_ack;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_code;
    logic [2:0]  stack_level;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [8:0] m_pc;
    logic [8:0] m_stk[$];
    logic       m_fault;
    logic [1:0] m_code;

    microcode_sequencer #(
        .RESET_PC(RST_PC), .IRQ_PC(IRQ_PC), .FAULT_PC(FLT_PC), .STACK_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .mc_next_op(mc_next_op), .mc_target(mc_target),
        .mc_cond_sel(mc_cond_sel), .cond_flags(cond_flags), .decoder_pc(decoder_pc),
        .decoder_valid(decoder_valid), .irq_pending(irq_pending), .stall(stall),
        .micro_pc(micro_pc), .micro_valid(micro_valid), .irq_ack(irq_ack),
        .halted(halted), .fault(fault), .fault_code(fault_code), .stack_level(stack_level)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Hold reset (with stall asserted to show it is ignored), check reset values,
    // release, and land in the first EXEC cycle at RESET_PC.
    task automatic do_reset();
        reset = 1'b1;
        stall = 1'b1;
        step();
        step();
        check_eq("rst_pc", 32'(micro_pc), 32'(RST_PC));
        check_eq("rst_valid", 32'(micro_valid), 32'd0);
        check_eq("rst_ack", 32'(irq_ack), 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);
        check_eq("rst_fault", 32'(fault), 32'd0);
        check_eq("rst_code", 32'(fault_code), 32'd0);
        check_eq("rst_level", 32'(stack_level), 32'd0);
        reset = 1'b0;
        stall = 1'b0;
        mc_next_op = INC;
        step();
        m_pc = RST_PC;
        m_stk.delete();
        m_fault = 1'b0;
        m_code = 2'b00;
        $display("txn reset -> pc=%03h", m_pc);
    endtask

    // Execute one microinstruction from an EXEC cycle, with nstall stall cycles.
    task automatic run_op(input logic [2:0] op, input logic [8:0] tgt, input logic [3:0] sel,
                          input logic [15:0] flg, input logic [8:0] dpc, input logic dv,
                          input logic irq, input int nstall);
        logic [8:0] nxt;
        bit hold;
        bit do_halt;
        bit ack;
        check_eq("exec_valid", 32'(micro_valid), 32'd1);
        check_eq("exec_pc", 32'(micro_pc), 32'(m_pc));
        check_eq("exec_level", 32'(stack_level), 32'(m_stk.size()));
        check_eq("exec_fault", 32'(fault), 32'(m_fault));
        check_eq("exec_code", 32'(fault_code), 32'(m_code));
        check_eq("exec_halted", 32'(halted), 32'd0);
        check_eq("exec_ack", 32'(irq_ack), 32'd0);

        mc_next_op = op; mc_target = tgt; mc_cond_sel = sel; cond_flags = flg;
        decoder_pc = dpc; decoder_valid = dv; irq_pending = irq;
        stall = 1'b1;
        for (int i = 0; i < nstall; i++) begin
            step();
            check_eq("stall_pc", 32'(micro_pc), 32'(m_pc));
            check_eq("stall_valid", 32'(micro_valid), 32'd1);
        end
        stall = 1'b0;

        hold = 0; do_halt = 0; ack = 0; nxt = m_pc;
        case (op)
            INC:  nxt = m_pc + 9'd1;
            JUMP: nxt = tgt;
            BR_T: nxt = flg[sel] ? tgt : m_pc + 9'd1;
            BR_F: nxt = flg[sel] ? m_pc + 9'd1 : tgt;
            CALL: begin
                if (m_stk.size() == DEPTH) begin
                    m_stk.delete();
                    m_fault = 1'b1;
                    if (m_code == 2'b00) m_code = 2'b01;
                    nxt = FLT_PC;
                end else begin
                    m_stk.push_back(m_pc + 9'd1);
                    nxt = tgt;
                end
            end
            RET: begin
                if (m_stk.size() == 0) begin
                    m_fault = 1'b1;
                    if (m_code == 2'b00) m_code = 2'b10;
                    nxt = FLT_PC;
                end else begin
                    nxt = m_stk.pop_back();
                end
            end
            DISP: begin
                if (irq) begin
                    nxt = IRQ_PC;
                    ack = 1;
                end else if (dv) begin
                    nxt = dpc;
                end else begin
                    hold = 1;
                end
            end
            default: do_halt = 1;
        endcase

        step();
        if (hold) begin
            check_eq("hold_valid", 32'(micro_valid), 32'd1);
            check_eq("hold_pc", 32'(micro_pc), 32'(m_pc));
        end else if (do_halt) begin
            check_eq("halt_flag", 32'(halted), 32'd1);
            check_eq("halt_valid", 32'(micro_valid), 32'd0);
            check_eq("halt_pc", 32'(micro_pc), 32'(m_pc));
        end else begin
            check_eq("fetch_valid", 32'(micro_valid), 32'd0);
            check_eq("fetch_pc", 32'(micro_pc), 32'(nxt));
            check_eq("fetch_ack", 32'(irq_ack), 32'(ack));
            check_eq("fetch_level", 32'(stack_level), 32'(m_stk.size()));
            step();
            check_eq("ack_pulse", 32'(irq_ack), 32'd0);
            m_pc = nxt;
        end
        $display("txn op=%0d stalls=%0d -> pc=%03h level=%0d code=%0d", op, nstall, m_pc,
                 m_stk.size(), m_code);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] rop;
        do_reset();

        // INC stream and wrap at 511
        for (int i = 0; i < 4; i++) run_op(INC, 9'd0, 4'd0, 16'd0, 9'd0, 1'b0, 1'b0, 0);
        run_op(JUMP, 9'd511, 4'd0, 16'd0, 9'd0, 1'b0, 1'b0, 0);
        run_op(INC, 9'd0, 4'd0, 16'd0, 9'd0, 1'b0, 1'b0, 0);

        // Branches on flag 5
        run_op(JUMP, 9'h020, 4'd0, 16'd0, 9'd0, 1'b0, 1'b0, 0);
        run_op(BR_T, 9'h040, 4'd5, 16'h0020, 9'd0, 1'b0, 1'b0, 0);
        run_op(BR_T, 9'h100, 4'd5, 16'hFFDF, 9'd0, 1'b0, 1'b0, 0);
        run_op(BR_F, 9'h040, 4'd5, 16'hFFDF, 9'd0, 1'b0, 1'b0, 0);
        run_op(BR_F, 9'h100, 4'd5, 16'h0020, 9'd0, 1'b0, 1'b0, 0);

        // Nested call/return
        run_op(JUMP, 9'd10, 4'd0, 16'd0, 9'd0, 1'b0, 1'b0, 0);
        run_op(CALL, 9'd100, 4'd0, 16'd0, 9'd0, 1'b0, 1'b0, 0);
        run_op(CALL, 9'd200, 4'd0, 16'd0, 9'd0, 1'b0, 1'b0, 0);
        check_eq("call_level2", 32'(stack_level), 32'd2);
        run_op(RET, 9'd0, 4'd0, 16'd0, 9'd0, 1'b0, 1'b0, 0);
        run_op(RET, 9'd0, 4'd0, 16'd0, 9'd0, 1'b0, 1'b0, 0);
        check_eq("ret_pc11", 32'(micro_pc), 32'd11);

        // Overflow on the fifth CALL
        for (int i = 0; i < 5; i++) run_op(CALL, 9'(50 + i * 10), 4'd0, 16'd0, 9'd0, 1'b0, 1'b0, 0);
        check_eq("ovf_pc", 32'(micro_pc), 32'd490);
        check_eq("ovf_code", 32'(fault_code), 32'd1);

        // Dispatch: wait, decoder entry, then IRQ beating the decoder
        for (int i = 0; i < 3; i++) run_op(DISP, 9'd0, 4'd0, 16'd0, 9'h1FF, 1'b0, 1'b0, 0);
        run_op(DISP, 9'd0, 4'd0, 16'd0, 9'h123, 1'b1, 1'b0, 0);
        run_op(DISP, 9'd0, 4'd0, 16'd0, 9'h055, 1'b1, 1'b1, 0);
        check_eq("irq_pc", 32'(micro_pc), 32'(IRQ_PC));

        // Long stall on a JUMP
        run_op(JUMP, 9'h0AA, 4'd0, 16'd0, 9'd0, 1'b0, 1'b0, 5);

        // Random microinstruction stream
        for (int n = 0; n < 250; n++) begin
            rop = 3'($urandom_range(0, 6));
            run_op(rop, 9'($urandom), 4'($urandom), 16'($urandom), 9'($urandom),
                   1'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
            if (n == 120) do_reset();
        end

        // RET on empty stack after a clean reset, then HALT and reset out of it
        do_reset();
        run_op(RET, 9'd0, 4'd0, 16'd0, 9'd0, 1'b0, 1'b0, 0);
        check_eq("unf_code", 32'(fault_code), 32'd2);
        run_op(INC, 9'd0, 4'd0, 16'd0, 9'd0, 1'b0, 1'b0, 1);
        run_op(HALT, 9'd0, 4'd0, 16'd0, 9'd0, 1'b0, 1'b0, 2);
        for (int i = 0; i < 3; i++) begin
            mc_next_op = JUMP;
            mc_target = 9'($urandom);
            stall = 1'($urandom);
            step();
            check_eq("halt_hold_pc", 32'(micro_pc), 32'(m_pc));
            check_eq("halt_hold_flag", 32'(halted), 32'd1);
            check_eq("halt_hold_valid", 32'(micro_valid), 32'd0);
        end
        do_reset();
        run_op(INC, 9'd0, 4'd0, 16'd0, 9'd0, 1'b0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
